// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if -- handshake and data bundle for mac_accumulator.
//
// Parameters:
//   SIZE       operand width of the feeding multiplier (product is 2*SIZE)
//   ACC_WIDTH  accumulator width
//
// Signals:
//   start      begin a new run (clears accumulator, counter, overflow)
//   in_valid   product presented by the producer
//   in_ready   accumulator accepts a product this cycle
//   product    unsigned product, 2*SIZE bits
//   out_valid  acc holds a completed sum
//   out_ready  consumer takes the result
//   acc        running / final unsigned sum
//   overflow   sticky overflow flag for the current run
//   busy       run in progress or result waiting
//
// Modports: master = producer/consumer side, slave = accumulator side.
interface mac_accumulator_if #(
    parameter int SIZE      = 8,
    parameter int ACC_WIDTH = 20
);
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [2*SIZE-1:0]     product;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  acc;
    logic                  overflow;
    logic                  busy;

    modport master (
        output start, in_valid, product, out_ready,
        input  in_ready, out_valid, acc, overflow, busy
    );

    modport slave (
        input  start, in_valid, product, out_ready,
        output in_ready, out_valid, acc, overflow, busy
    );
endinterface

// File: rtl/mac_accumulator.sv
// mac_accumulator -- sums TERMS unsigned products from a multiplier and
// presents the total through a valid/ready handshake.
//
// Parameters:
//   SIZE       operand width of the multiplier (product is 2*SIZE bits)
//   ACC_WIDTH  accumulator width, must be >= 2*SIZE
//   TERMS      products summed per run, must be >= 1
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        mac_accumulator_if.slave (start, in_valid/in_ready/product,
//              out_valid/out_ready/acc, overflow, busy)
//
// Build option:
//   MAC_ACCUMULATOR_SATURATE_EN  defined   -> acc clamps at 2^ACC_WIDTH-1
//                                undefined -> acc wraps modulo 2^ACC_WIDTH
//   The overflow flag behaves the same in both builds.
module mac_accumulator #(
    parameter int SIZE      = 8,
    parameter int ACC_WIDTH = 20,
    parameter int TERMS     = 4
) (
    input logic             clk,
    input logic             rst,
    mac_accumulator_if.slave bus
);

    if (ACC_WIDTH < 2*SIZE) begin : g_acc_width_check
        $error("mac_accumulator: ACC_WIDTH must be at least 2*SIZE");
    end
    if (TERMS < 1) begin : g_terms_check
        $error("mac_accumulator: TERMS must be at least 1");
    end

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Counter must be able to hold TERMS itself.
    localparam int CW = (TERMS < 1) ? 1 : $clog2(TERMS + 1);
    localparam logic [CW-1:0] LAST = CW'(TERMS - 1);

    logic [1:0]           state;
    logic [CW-1:0]        count;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_q;

    logic                 xfer;
    logic                 start_run;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic [ACC_WIDTH-1:0] acc_next;

    assign xfer = bus.in_valid && (state == ACCUM);

    // Start is honoured everywhere except in DONE while the result has not
    // been taken; there it would destroy an unread result.
    assign start_run = bus.start &&
                       ((state == IDLE) || (state == ACCUM) ||
                        ((state == DONE) && bus.out_ready));

    // One extra bit catches the carry out of the accumulator.
    assign sum   = {1'b0, acc_q} + (ACC_WIDTH+1)'(bus.product);
    assign carry = sum[ACC_WIDTH];

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    // Once clamped, every further non-zero add carries again, so acc stays
    // pinned at all-ones for the rest of the run.
    assign acc_next = carry ? '1 : sum[ACC_WIDTH-1:0];
`else
    assign acc_next = sum[ACC_WIDTH-1:0];
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (start_run) begin
            // Start beats a transfer in the same cycle: the product is dropped.
            state <= ACCUM;
            count <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                ACCUM: begin
                    if (xfer) begin
                        acc_q <= acc_next;
                        ovf_q <= ovf_q | carry;
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == ACCUM) || (state == DONE);
    assign bus.acc       = acc_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator -- directed bench for mac_accumulator.
// Instance a: SIZE=8, ACC_WIDTH=20, TERMS=4; results checked by a scoreboard
// queue popped on every out_valid&out_ready handshake.
// Instance b: SIZE=8, ACC_WIDTH=17, TERMS=4; overflow / wrap / clamp run.
module tb_mac_accumulator;

    typedef struct packed {
        logic [19:0] acc;
        logic        overflow;
    } result_t;

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    localparam logic [16:0] B_AFTER3 = 17'h1FFFF;
    localparam logic [16:0] B_FINAL  = 17'h1FFFF;
`else
    localparam logic [16:0] B_AFTER3 = 17'h0FFFA;
    localparam logic [16:0] B_FINAL  = 17'h1FFF8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    result_t exp_q[$];

    mac_accumulator_if #(.SIZE(8), .ACC_WIDTH(20)) a_if ();
    mac_accumulator_if #(.SIZE(8), .ACC_WIDTH(17)) b_if ();

    mac_accumulator #(.SIZE(8), .ACC_WIDTH(20), .TERMS(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    mac_accumulator #(.SIZE(8), .ACC_WIDTH(17), .TERMS(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (a_if.out_valid && a_if.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got acc 0x%0h, expected no result (t=%0t)",
                         a_if.acc, $time);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                check("sb_acc", 32'(a_if.acc), 32'(e.acc));
                check("sb_overflow", 32'(a_if.overflow), 32'(e.overflow));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_xfer(input logic [15:0] p);
        a_if.in_valid = 1'b1;
        a_if.product  = p;
        step();
        a_if.in_valid = 1'b0;
    endtask

    task automatic a_start();
        a_if.start = 1'b1;
        step();
        a_if.start = 1'b0;
    endtask

    task automatic a_check_idle(input string name);
        check({name, "_in_ready"},  32'(a_if.in_ready),  32'd0);
        check({name, "_out_valid"}, 32'(a_if.out_valid), 32'd0);
        check({name, "_busy"},      32'(a_if.busy),      32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.start = 1'b0; a_if.in_valid = 1'b0; a_if.product = '0; a_if.out_ready = 1'b1;
        b_if.start = 1'b0; b_if.in_valid = 1'b0; b_if.product = '0; b_if.out_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        a_check_idle("reset");
        check("reset_acc", 32'(a_if.acc), 32'd0);
        check("reset_overflow", 32'(a_if.overflow), 32'd0);

        // Basic run 3,5,7,11 back-to-back -> 0x1A
        a_start();
        check("start_in_ready", 32'(a_if.in_ready), 32'd1);
        check("start_busy", 32'(a_if.busy), 32'd1);
        check("start_acc", 32'(a_if.acc), 32'd0);
        exp_q.push_back('{acc: 20'h0001A, overflow: 1'b0});
        a_xfer(16'd3);
        a_xfer(16'd5);
        a_xfer(16'd7);
        check("basic_no_early_valid", 32'(a_if.out_valid), 32'd0);
        a_xfer(16'd11);
        check("basic_out_valid", 32'(a_if.out_valid), 32'd1);
        check("basic_in_ready_done", 32'(a_if.in_ready), 32'd0);
        step();
        a_check_idle("basic_idle");

        // Result held in DONE while out_ready=0; stray product and start ignored
        a_if.out_ready = 1'b0;
        a_start();
        exp_q.push_back('{acc: 20'd10, overflow: 1'b0});
        a_xfer(16'd1);
        a_xfer(16'd2);
        a_xfer(16'd3);
        a_xfer(16'd4);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a_if.in_valid = 1'b1;
                a_if.product  = 16'd9;
            end
            if (i == 3) a_if.start = 1'b1;
            step();
            a_if.in_valid = 1'b0;
            a_if.start    = 1'b0;
            check("hold_acc", 32'(a_if.acc), 32'd10);
            check("hold_in_ready", 32'(a_if.in_ready), 32'd0);
            check("hold_out_valid", 32'(a_if.out_valid), 32'd1);
        end
        a_if.out_ready = 1'b1;
        step();
        a_check_idle("hold_release");

        // Start mid-run discards partial sum and the concurrent product
        a_start();
        a_xfer(16'd2);
        a_xfer(16'd4);
        a_if.start    = 1'b1;
        a_if.in_valid = 1'b1;
        a_if.product  = 16'd100;
        step();
        a_if.start    = 1'b0;
        a_if.in_valid = 1'b0;
        check("restart_acc", 32'(a_if.acc), 32'd0);
        check("restart_in_ready", 32'(a_if.in_ready), 32'd1);
        exp_q.push_back('{acc: 20'd4, overflow: 1'b0});
        a_xfer(16'd1);
        a_xfer(16'd1);
        a_xfer(16'd1);
        check("restart_count_cleared", 32'(a_if.out_valid), 32'd0);
        a_xfer(16'd1);
        check("restart_out_valid", 32'(a_if.out_valid), 32'd1);

        // Start together with out_ready in DONE: handshake and fresh run
        a_start();
        check("done_start_in_ready", 32'(a_if.in_ready), 32'd1);
        check("done_start_out_valid", 32'(a_if.out_valid), 32'd0);
        check("done_start_acc", 32'(a_if.acc), 32'd0);

        // Reset mid-run: partial sum dropped, no result handshake
        a_xfer(16'd5);
        a_xfer(16'd6);
        a_xfer(16'd7);
        check("pre_rst_acc", 32'(a_if.acc), 32'd18);
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_check_idle("midrun_rst");
        check("midrun_rst_acc", 32'(a_if.acc), 32'd0);
        check("midrun_rst_overflow", 32'(a_if.overflow), 32'd0);
        a_start();
        exp_q.push_back('{acc: 20'd10, overflow: 1'b0});
        a_xfer(16'd1);
        a_xfer(16'd2);
        a_xfer(16'd3);
        a_xfer(16'd4);
        step();

        // Gaps: in_valid every other cycle, products 0xFF
        a_start();
        exp_q.push_back('{acc: 20'h003FC, overflow: 1'b0});
        for (int i = 0; i < 4; i++) begin
            a_xfer(16'h00FF);
            if (i < 3) begin
                step();
                check("gap_acc", 32'(a_if.acc), 32'((i + 1) * 255));
                check("gap_in_ready", 32'(a_if.in_ready), 32'd1);
            end
        end
        check("gap_out_valid", 32'(a_if.out_valid), 32'd1);
        step();
        a_check_idle("gap_idle");

        // Narrow accumulator: four 0xFFFE products overflow 17 bits
        b_if.start = 1'b1;
        step();
        b_if.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_if.in_valid = 1'b1;
            b_if.product  = 16'hFFFE;
            step();
            b_if.in_valid = 1'b0;
            if (i == 1) begin
                check("ovf_not_yet", 32'(b_if.overflow), 32'd0);
                check("ovf_acc2", 32'(b_if.acc), 32'h1FFFC);
            end
            if (i == 2) begin
                check("ovf_set", 32'(b_if.overflow), 32'd1);
                check("ovf_acc3", 32'(b_if.acc), 32'(B_AFTER3));
            end
        end
        check("ovf_out_valid", 32'(b_if.out_valid), 32'd1);
        check("ovf_final_acc", 32'(b_if.acc), 32'(B_FINAL));
        check("ovf_final_flag", 32'(b_if.overflow), 32'd1);
        step();
        check("ovf_hold_acc", 32'(b_if.acc), 32'(B_FINAL));
        check("ovf_hold_flag", 32'(b_if.overflow), 32'd1);
        b_if.start     = 1'b1;
        b_if.out_ready = 1'b1;
        step();
        b_if.start     = 1'b0;
        b_if.out_ready = 1'b0;
        check("ovf_cleared_flag", 32'(b_if.overflow), 32'd0);
        check("ovf_cleared_acc", 32'(b_if.acc), 32'd0);
        check("ovf_cleared_in_ready", 32'(b_if.in_ready), 32'd1);

        step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
